// File: rtl/bus_ram_responder_if.sv
// ---------------------------------------------------------------------------
// bus_ram_responder_if
//   CPU-side bus bundle between an initiator (CPU) and the RAM responder.
//   Signals:
//     A_BUS  [15:0]  address from the initiator
//     D_IN   [7:0]   write data from the initiator
//     RW             1 = read, 0 = write
//     VALID          bus-cycle strobe; a request is only sampled while high
//     D_OUT  [7:0]   read data from the responder
//     D_OE           responder drives the shared data bus
//     RDY            low = initiator must stall
//     SEL            combinational address-window hit
//   Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface bus_ram_responder_if;
  logic [15:0] A_BUS;
  logic [7:0]  D_IN;
  logic        RW;
  logic        VALID;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic        RDY;
  logic        SEL;

  modport master (
    output A_BUS, D_IN, RW, VALID,
    input  D_OUT, D_OE, RDY, SEL
  );

  modport slave (
    input  A_BUS, D_IN, RW, VALID,
    output D_OUT, D_OE, RDY, SEL
  );
endinterface

// File: rtl/bus_ram_responder.sv
// ---------------------------------------------------------------------------
// bus_ram_responder
//   Synchronous byte-wide RAM that answers CPU bus cycles inside a
//   power-of-two address window. Each accepted access is stretched by
//   WAIT_STATES cycles of RDY low; read data is presented with D_OE high for
//   one cycle once the access completes. A new request may be accepted in
//   the data cycle of the previous one, so accesses run back-to-back.
//   Ports:
//     clk  system clock, rising edge
//     RST  asynchronous, active-high reset
//     bus  responder side of bus_ram_responder_if (A_BUS, D_IN, RW, VALID
//          in; D_OUT, D_OE, RDY, SEL out)
// ---------------------------------------------------------------------------
module bus_ram_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          ADDR_BITS   = 11,
  parameter int          WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   RST,
  bus_ram_responder_if.slave     bus
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   rw_q;
  logic [7:0]             wdata_q;
  logic [7:0]             d_out_q;
  logic                   d_oe_q, d_oe_d;
  logic                   rdy_q, rdy_d;

  logic [7:0]             mem [0:DEPTH-1];

  logic                   sel;
  logic                   accept;
  logic                   do_access;
  logic [ADDR_BITS-1:0]   addr_eff;
  logic                   rw_eff;
  logic [7:0]             wdata_eff;

  assign sel    = (bus.A_BUS[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
  // WAIT ignores the bus entirely; IDLE and DATA both accept new requests.
  assign accept = bus.VALID && sel && (state_q != S_WAIT);

  // With zero wait states the access happens on the accepting edge itself,
  // so the live bus values are used; otherwise the latched copies are.
  assign addr_eff  = accept ? bus.A_BUS[ADDR_BITS-1:0] : addr_q;
  assign rw_eff    = accept ? bus.RW                   : rw_q;
  assign wdata_eff = accept ? bus.D_IN                 : wdata_q;

  assign do_access = (accept && (WAIT_STATES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 3'd0));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    rdy_d  = (state_d != S_WAIT);
    d_oe_d = (state_d == S_DATA) && rw_eff;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      wdata_q <= 8'h00;
      d_out_q <= 8'h00;
      d_oe_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_oe_q  <= d_oe_d;
      rdy_q   <= rdy_d;
      if (accept) begin
        addr_q  <= bus.A_BUS[ADDR_BITS-1:0];
        rw_q    <= bus.RW;
        wdata_q <= bus.D_IN;
      end
      if (do_access && rw_eff) d_out_q <= mem[addr_eff];
    end
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM; only the
  // write enable is held off while RST is asserted.
  always_ff @(posedge clk) begin
    if (!RST && do_access && !rw_eff) mem[addr_eff] <= wdata_eff;
  end

  assign bus.D_OUT = d_out_q;
  assign bus.D_OE  = d_oe_q;
  assign bus.RDY   = rdy_q;
  assign bus.SEL   = sel;

endmodule

// File: tb/tb_bus_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_ram_responder
//   Four responders with WAIT_STATES = 0..3 (instance k has k wait states),
//   each on its own bus bundle and reset. Expected read data is pushed to a
//   queue when a read is issued and popped when D_OE shows the data.
// ---------------------------------------------------------------------------
module tb_bus_ram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [4];
  logic [15:0] a_bus [4];
  logic [7:0]  d_in  [4];
  logic        rw_s  [4];
  logic        valid [4];
  logic [7:0]  d_out [4];
  logic        d_oe  [4];
  logic        rdy   [4];
  logic        sel   [4];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    bus_ram_responder_if bif ();
    assign bif.A_BUS = a_bus[k];
    assign bif.D_IN  = d_in[k];
    assign bif.RW    = rw_s[k];
    assign bif.VALID = valid[k];
    assign d_out[k]  = bif.D_OUT;
    assign d_oe[k]   = bif.D_OE;
    assign rdy[k]    = bif.RDY;
    assign sel[k]    = bif.SEL;

    bus_ram_responder #(
      .BASE_ADDR   (16'h0000),
      .ADDR_BITS   (11),
      .WAIT_STATES (k)
    ) u_dut (
      .clk (clk),
      .RST (rst[k]),
      .bus (bif)
    );
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] model [4][2048];
  logic [7:0] exp_q [$];

  // One complete access on instance k (k wait states), followed by an idle
  // cycle. Bus inputs are scrambled after the accept edge to show that only
  // the latched request matters.
  task automatic do_access(input int k, input logic [15:0] addr, input logic rw,
                           input logic [7:0] data, input string tag);
    logic [7:0] e;
    @(negedge clk);
    a_bus[k] = addr; d_in[k] = data; rw_s[k] = rw; valid[k] = 1'b1;
    if (!rw) model[k][addr[10:0]] = data;
    else     exp_q.push_back(model[k][addr[10:0]]);
    @(posedge clk);
    @(negedge clk);
    valid[k] = 1'b0; a_bus[k] = addr ^ 16'h0005; d_in[k] = ~data; rw_s[k] = ~rw;
    for (int i = 0; i < k; i++) begin
      n_vec++;
      if (rdy[k] !== 1'b0) begin
        n_err++; $display("FAIL %s rdy_wait%0d: got %b want 0", tag, i, rdy[k]);
      end
      @(negedge clk);
    end
    n_vec++;
    if (rdy[k] !== 1'b1) begin
      n_err++; $display("FAIL %s rdy_data: got %b want 1", tag, rdy[k]);
    end
    n_vec++;
    if (d_oe[k] !== rw) begin
      n_err++; $display("FAIL %s d_oe_data: got %b want %b", tag, d_oe[k], rw);
    end
    if (rw) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_vec++;
      if (d_out[k] !== e) begin
        n_err++; $display("FAIL %s d_out: got %h want %h", tag, d_out[k], e);
      end
    end
    @(negedge clk);
    n_vec++;
    if (d_oe[k] !== 1'b0 || rdy[k] !== 1'b1) begin
      n_err++; $display("FAIL %s after: d_oe=%b rdy=%b want d_oe=0 rdy=1", tag, d_oe[k], rdy[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; valid[k] = 1'b0; a_bus[k] = 16'h0000; d_in[k] = 8'h00; rw_s[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (rdy[k] !== 1'b1 || d_oe[k] !== 1'b0 || d_out[k] !== 8'h00) begin
        n_err++;
        $display("FAIL reset%0d: rdy=%b d_oe=%b d_out=%h want rdy=1 d_oe=0 d_out=00",
                 k, rdy[k], d_oe[k], d_out[k]);
      end
    end
  endtask

  task automatic test_zero_wait();
    do_access(0, 16'h0010, 1'b0, 8'hA5, "ws0_wr");
    do_access(0, 16'h0010, 1'b1, 8'h00, "ws0_rd");
  endtask

  task automatic test_two_wait();
    do_access(2, 16'h0010, 1'b0, 8'hA5, "ws2_wr");
    do_access(2, 16'h0010, 1'b1, 8'h00, "ws2_rd");
  endtask

  task automatic test_out_of_window();
    do_access(0, 16'h0000, 1'b0, 8'h5A, "oow_init");
    @(negedge clk);
    a_bus[0] = 16'h0010; #1;
    n_vec++;
    if (sel[0] !== 1'b1) begin
      n_err++; $display("FAIL sel_hit: got %b want 1", sel[0]);
    end
    a_bus[0] = 16'h8000; rw_s[0] = 1'b0; d_in[0] = 8'hFF; valid[0] = 1'b1; #1;
    n_vec++;
    if (sel[0] !== 1'b0) begin
      n_err++; $display("FAIL sel_miss: got %b want 0", sel[0]);
    end
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (rdy[0] !== 1'b1 || d_oe[0] !== 1'b0) begin
        n_err++; $display("FAIL oow_idle: rdy=%b d_oe=%b want rdy=1 d_oe=0", rdy[0], d_oe[0]);
      end
    end
    valid[0] = 1'b0;
    do_access(0, 16'h0000, 1'b1, 8'h00, "oow_rd");
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    @(negedge clk);
    a_bus[1] = 16'h07FF; d_in[1] = 8'h3C; rw_s[1] = 1'b0; valid[1] = 1'b1;
    model[1][11'h7FF] = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (rdy[1] !== 1'b0) begin
      n_err++; $display("FAIL b2b_wr_wait: rdy got %b want 0", rdy[1]);
    end
    // Read request presented during WAIT; it must only be taken in DATA.
    rw_s[1] = 1'b1; d_in[1] = 8'h00;
    exp_q.push_back(model[1][11'h7FF]);
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (rdy[1] !== 1'b1 || d_oe[1] !== 1'b0) begin
      n_err++; $display("FAIL b2b_wr_data: rdy=%b d_oe=%b want rdy=1 d_oe=0", rdy[1], d_oe[1]);
    end
    @(posedge clk);
    @(negedge clk);
    valid[1] = 1'b0;
    n_vec++;
    if (rdy[1] !== 1'b0) begin
      n_err++; $display("FAIL b2b_no_bubble: rdy got %b want 0", rdy[1]);
    end
    @(posedge clk);
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_vec++;
    if (rdy[1] !== 1'b1 || d_oe[1] !== 1'b1 || d_out[1] !== e) begin
      n_err++;
      $display("FAIL b2b_rd: rdy=%b d_oe=%b d_out=%h want rdy=1 d_oe=1 d_out=%h",
               rdy[1], d_oe[1], d_out[1], e);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_access(3, 16'h0020, 1'b0, 8'h77, "rst_init");
    @(negedge clk);
    a_bus[3] = 16'h0020; d_in[3] = 8'h11; rw_s[3] = 1'b0; valid[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[3] = 1'b0;
    n_vec++;
    if (rdy[3] !== 1'b0) begin
      n_err++; $display("FAIL rst_pre: rdy got %b want 0", rdy[3]);
    end
    rst[3] = 1'b1; #1;
    n_vec++;
    if (rdy[3] !== 1'b1 || d_oe[3] !== 1'b0) begin
      n_err++; $display("FAIL rst_async: rdy=%b d_oe=%b want rdy=1 d_oe=0", rdy[3], d_oe[3]);
    end
    @(negedge clk);
    rst[3] = 1'b0;
    do_access(3, 16'h0020, 1'b1, 8'h00, "rst_rd");
  endtask

  task automatic test_valid_low();
    do_access(1, 16'h0010, 1'b0, 8'h42, "vl_init");
    a_bus[1] = 16'h0010; d_in[1] = 8'hEE; rw_s[1] = 1'b0; valid[1] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      n_vec++;
      if (rdy[1] !== 1'b1 || d_oe[1] !== 1'b0) begin
        n_err++; $display("FAIL vl_idle: rdy=%b d_oe=%b want rdy=1 d_oe=0", rdy[1], d_oe[1]);
      end
    end
    do_access(1, 16'h0010, 1'b1, 8'h00, "vl_rd");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_two_wait();
    test_out_of_window();
    test_back_to_back();
    test_reset_mid_wait();
    test_valid_low();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_ram_responder.md
Name: bus_ram_responder

Overview:
- Synchronous RAM target on the CPU address/data bus; the responder end of the CPU bus cycle.
- Decodes a power-of-two address window and services reads and writes.
- Inserts a programmable number of wait states by holding RDY low.
- Sits beside program_rom on A_BUS and supplies writable storage (zero page, stack) to the CPU.

Parameters:
BASE_ADDR, 16'h0000, window base; only bits [15:ADDR_BITS] are compared.
ADDR_BITS, 11, window size is 2^ADDR_BITS bytes; legal range 4..15.
WAIT_STATES, 1, RDY-low cycles inserted per access; legal range 0..7.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
RST  in  1  asynchronous, active-high reset.
A_BUS  in  16  address from CPU.
D_IN  in  8  write data from CPU.
RW  in  1  1 = read, 0 = write.
VALID  in  1  bus-cycle strobe from the initiator; the request is sampled only when this is high.
D_OUT  out  8  read data.
D_OE  out  1  high when D_OUT must drive the shared data bus.
RDY  out  1  low = initiator must stall.
SEL  out  1  combinational window hit: A_BUS[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS].

Behaviour:
- Clock and reset:
  - One clock, clk.
  - RST is asynchronous and active-high.
- Reset values:
  - Registered outputs: D_OUT=8'h00, D_OE=0, RDY=1.
  - FSM=IDLE, wait counter=0.
  - Memory contents are not cleared. Undriven contents read as X in simulation.
- Request acceptance: a request is accepted at an edge where VALID & SEL = 1 and the FSM is in IDLE or DATA. Call that edge E0.
  - At E0 the block latches A_BUS[ADDR_BITS-1:0], RW and D_IN.
  - The access uses the latched values only. Later changes on the bus inputs during the access have no effect.
- FSM states: IDLE, WAIT, DATA.
- IDLE:
  - Outputs: RDY=1, D_OE=0.
  - On accept with WAIT_STATES=0: perform the access at E0 and go to DATA.
  - On accept with WAIT_STATES>0: load cnt=WAIT_STATES-1 and go to WAIT.
- WAIT:
  - Outputs: RDY=0, D_OE=0.
  - If cnt=0: perform the access and go to DATA. Otherwise cnt decrements.
  - VALID and A_BUS are ignored while in WAIT.
- Performing an access:
  - Write (RW=0): mem[addr] <= latched data.
  - Read: D_OUT <= mem[addr].
  - D_OUT holds its value after a read and is not updated by writes.
- DATA:
  - Outputs: RDY=1. D_OE=1 only for a read, 0 for a write.
  - On the next edge: a new accept is handled exactly as in IDLE (back-to-back accesses, no bubble); otherwise go to IDLE.
- Latency:
  - RDY is low for exactly WAIT_STATES cycles following E0.
  - Read data is valid, with D_OE=1, for the single cycle following E0+WAIT_STATES edges.
- Address width: only A_BUS[ADDR_BITS-1:0] indexes memory. No address wrap is possible inside the window.
- Outside the window (VALID high, SEL low): no state change, RDY stays 1, D_OE stays 0, memory untouched.
- VALID low: no access, regardless of SEL.
- Reset mid-operation (RST in WAIT or DATA):
  - Immediate return to IDLE; RDY=1, D_OE=0.
  - A pending (not yet performed) write is discarded.
  - A write already performed is kept.
- Read-after-write to the same address in a back-to-back cycle returns the new data.

Test Plan:
- WAIT_STATES=0, BASE=16'h0000; write 8'hA5 to 16'h0010, then read 16'h0010 -> RDY never low; D_OUT=8'hA5 with D_OE=1 in the cycle after the read's E0.
- WAIT_STATES=2; read 16'h0010 -> RDY=0 for 2 cycles after E0; D_OUT=8'hA5, D_OE=1 in the 3rd cycle after E0; D_OE=0 afterwards.
- Out-of-window: VALID=1, A_BUS=16'h8000, RW=0, D_IN=8'hFF -> SEL=0, RDY=1, D_OE=0; a later read of 16'h0000 returns its prior value.
- Back-to-back, WAIT_STATES=1: write 8'h3C to 16'h07FF, immediately followed by a read of 16'h07FF accepted in DATA -> read returns 8'h3C; no IDLE cycle between the two accesses.
- Reset mid-WAIT, WAIT_STATES=3: write 8'h11 to 16'h0020; assert RST in the 1st WAIT cycle -> RDY=1 and D_OE=0 immediately; a later read of 16'h0020 returns the old value, not 8'h11.
- VALID=0 with an in-window address for 10 cycles -> no FSM activity; RDY=1, D_OE=0 throughout.
